// File: rtl/vip_ycbcr422_ycbcr444.sv
// YCbCr 4:2:2 to 4:4:4 upsampler: holds one pixel so each output carries its own Cb/Cr pair,
// flushes the held pixel after href falls, and delays vsync/href by two clocks to frame the result.
module vip_ycbcr422_ycbcr444 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [15:0] per_img_data,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] post_img_data
);

    localparam logic [7:0] C_MID = 8'd128;

    logic [7:0]  y_in_s;
    logic [7:0]  c_in_s;
    logic        beat_s;
    logic        line_start_s;
    logic        held_s;
    logic        flush_s;

    logic        href_prev_q;
    logic        phase_q,      phase_d;
    logic [7:0]  y_hold_q,     y_hold_d;
    logic [7:0]  cb_new_q,     cb_new_d;
    logic [7:0]  cb_pair_q,    cb_pair_d;
    logic [7:0]  cr_pair_q,    cr_pair_d;
    logic        hold_valid_q, hold_valid_d;
    logic [1:0]  vsync_dly_q;
    logic [1:0]  href_dly_q;
    logic        out_clken_q,  out_clken_d;
    logic [23:0] out_data_q,   out_data_d;

    // Input decode and line-edge detection.
    always_comb begin
        y_in_s       = per_img_data[15:8];
        c_in_s       = per_img_data[7:0];
        beat_s       = per_frame_clken & per_frame_href;
        line_start_s = per_frame_href & ~href_prev_q;
        // A pixel still held at a line start belongs to the old line and is dropped.
        held_s       = hold_valid_q & ~line_start_s;
        flush_s      = ~per_frame_href & href_prev_q & hold_valid_q;
    end

    // Next-state and output pixel selection.
    always_comb begin
        phase_d      = phase_q;
        y_hold_d     = y_hold_q;
        cb_new_d     = cb_new_q;
        cb_pair_d    = cb_pair_q;
        cr_pair_d    = cr_pair_q;
        hold_valid_d = hold_valid_q;
        out_clken_d  = 1'b0;
        out_data_d   = 24'd0;

        if (per_frame_href) begin
            if (line_start_s) begin
                hold_valid_d = 1'b0;
            end else begin
                hold_valid_d = hold_valid_q;
            end

            if (beat_s) begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    if (held_s) begin
                        out_clken_d = 1'b1;
                        out_data_d  = {y_hold_q, cb_pair_q, cr_pair_q};
                    end else begin
                        out_clken_d = 1'b0;
                        out_data_d  = 24'd0;
                    end
                    y_hold_d     = y_in_s;
                    cb_new_d     = c_in_s;
                    hold_valid_d = 1'b1;
                end else begin
                    out_clken_d  = 1'b1;
                    out_data_d   = {y_hold_q, cb_new_q, c_in_s};
                    cb_pair_d    = cb_new_q;
                    cr_pair_d    = c_in_s;
                    y_hold_d     = y_in_s;
                    hold_valid_d = 1'b1;
                end
            end else begin
                phase_d = phase_q;
            end
        end else begin
            // Between lines: restart the phase and return the chroma pair to neutral.
            phase_d      = 1'b0;
            cb_pair_d    = C_MID;
            cr_pair_d    = C_MID;
            hold_valid_d = 1'b0;
            if (flush_s) begin
                out_clken_d = 1'b1;
                // phase_q=1 here means the line had an odd number of beats.
                if (phase_q) begin
                    out_data_d = {y_hold_q, cb_new_q, cr_pair_q};
                end else begin
                    out_data_d = {y_hold_q, cb_pair_q, cr_pair_q};
                end
            end else begin
                out_clken_d = 1'b0;
                out_data_d  = 24'd0;
            end
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_prev_q  <= 1'b0;
            phase_q      <= 1'b0;
            y_hold_q     <= 8'd0;
            cb_new_q     <= 8'd0;
            cb_pair_q    <= C_MID;
            cr_pair_q    <= C_MID;
            hold_valid_q <= 1'b0;
        end else begin
            href_prev_q  <= per_frame_href;
            phase_q      <= phase_d;
            y_hold_q     <= y_hold_d;
            cb_new_q     <= cb_new_d;
            cb_pair_q    <= cb_pair_d;
            cr_pair_q    <= cr_pair_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Two-stage sync delay and registered pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_dly_q <= 2'b00;
            href_dly_q  <= 2'b00;
            out_clken_q <= 1'b0;
            out_data_q  <= 24'd0;
        end else begin
            vsync_dly_q <= {vsync_dly_q[0], per_frame_vsync};
            href_dly_q  <= {href_dly_q[0], per_frame_href};
            out_clken_q <= out_clken_d;
            out_data_q  <= out_data_d;
        end
    end

    assign post_frame_vsync = vsync_dly_q[1];
    assign post_frame_href  = href_dly_q[1];
    assign post_frame_clken = out_clken_q;
    assign post_img_data    = out_data_q;

endmodule

// File: tb/tb_vip_ycbcr422_ycbcr444.sv
// Scoreboard bench for vip_ycbcr422_ycbcr444: a line-level reference model predicts every output
// pixel and the cycle it must appear in; a negedge monitor checks data, timing and sync delays.
module tb_vip_ycbcr422_ycbcr444;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [15:0] per_img_data;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [23:0] post_img_data;

    vip_ycbcr422_ycbcr444 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_data     (per_img_data),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_data    (post_img_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] px;
        int          at;
    } exp_t;

    exp_t       sbq[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         last_rst = 0;
    logic [7:0] ly[$];
    logic [7:0] lc[$];
    bit         prev_h = 1'b0;
    bit         cur_vs = 1'b0;
    bit         hist_h[256];
    bit         hist_v[256];
    logic [7:0] dy[16];
    logic [7:0] dc[16];

    // Pixel i of the current line: Cb from the even beat of its pair, Cr from the odd beat,
    // falling back to the previous pair's Cr (or neutral 128) when the pair is incomplete.
    function automatic logic [23:0] ref_pix(int i);
        int b;
        logic [7:0] cr;
        b = 2 * (i / 2);
        if (b + 1 < lc.size())
            cr = lc[b + 1];
        else if (i >= 2)
            cr = lc[b - 1];
        else
            cr = 8'd128;
        return {ly[i], lc[b], cr};
    endfunction

    task automatic push_exp(logic [23:0] px, int at);
        exp_t e;
        e.px = px;
        e.at = at;
        sbq.push_back(e);
    endtask

    task automatic drive(bit h, bit e, logic [7:0] y, logic [7:0] c);
        @(posedge clk);
        #1;
        per_frame_vsync = cur_vs;
        per_frame_href  = h;
        per_frame_clken = e;
        per_img_data    = {y, c};
        if (h && !prev_h) begin
            ly.delete();
            lc.delete();
        end
        if (h && e) begin
            ly.push_back(y);
            lc.push_back(c);
            if (ly.size() >= 2) push_exp(ref_pix(ly.size() - 2), cyc + 1);
        end
        if (!h && prev_h && ly.size() > 0) begin
            push_exp(ref_pix(ly.size() - 1), cyc + 1);
            ly.delete();
            lc.delete();
        end
        prev_h = h;
    endtask

    task automatic idle_hi();
        drive(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic send_line(int n, int gap, bit rnd, bit pulses);
        int g;
        if (rnd) repeat ($urandom_range(0, 2)) idle_hi();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                g = rnd ? int'($urandom_range(0, gap)) : gap;
                repeat (g) idle_hi();
            end
            drive(1'b1, 1'b1, dy[i], dc[i]);
        end
        repeat (2 + $urandom_range(0, 2))
            drive(1'b0, pulses ? 1'($urandom) : 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        prev_h          = 1'b0;
        ly.delete();
        lc.delete();
        for (int k = sbq.size() - 1; k >= 0; k--)
            if (sbq[k].at >= cyc) sbq.delete(k);
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_rst = cyc;
    endtask

    // Monitor: reset values, sync delay, scoreboard pops and idle data.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_vec++;
            if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data} !== 27'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got vs=%b hr=%b ce=%b d=%h, want all 0",
                         post_frame_vsync, post_frame_href, post_frame_clken, post_img_data);
            end
        end else begin
            if (cyc - last_rst > 3) begin
                n_vec++;
                if (post_frame_href !== hist_h[(cyc - 2) % 256] ||
                    post_frame_vsync !== hist_v[(cyc - 2) % 256]) begin
                    n_err++;
                    $display("FAIL sync_delay cyc %0d: got vs=%b hr=%b, want vs=%b hr=%b", cyc,
                             post_frame_vsync, post_frame_href,
                             hist_v[(cyc - 2) % 256], hist_h[(cyc - 2) % 256]);
                end
            end
            while (sbq.size() > 0 && sbq[0].at < cyc) begin
                e = sbq.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_pixel: got none by cyc %0d, want %h at cyc %0d", cyc, e.px, e.at);
            end
            n_vec++;
            if (post_frame_clken) begin
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat cyc %0d: got %h, want no beat", cyc, post_img_data);
                end else begin
                    e = sbq.pop_front();
                    if (post_img_data !== e.px || cyc != e.at || post_frame_href !== 1'b1) begin
                        n_err++;
                        $display("FAIL pixel: got %h at cyc %0d href=%b, want %h at cyc %0d href=1",
                                 post_img_data, cyc, post_frame_href, e.px, e.at);
                    end
                end
            end else if (post_img_data !== 24'd0) begin
                n_err++;
                $display("FAIL idle_data cyc %0d: got %h, want 000000", cyc, post_img_data);
            end
        end
        hist_h[cyc % 256] = per_frame_href;
        hist_v[cyc % 256] = per_frame_vsync;
    end

    task automatic set_px(int i, logic [7:0] y, logic [7:0] c);
        dy[i] = y;
        dc[i] = c;
    endtask

    initial begin
        rst_n           = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_data    = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_rst = cyc;
        repeat (3) drive(1'b0, 1'b0, 8'd0, 8'd0);

        cur_vs = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 8'd0, 8'd0);
        cur_vs = 1'b0;
        set_px(0, 8'd10, 8'd100); set_px(1, 8'd20, 8'd200);
        set_px(2, 8'd30, 8'd110); set_px(3, 8'd40, 8'd210);
        send_line(4, 0, 1'b0, 1'b0);
        send_line(3, 0, 1'b0, 1'b0);
        set_px(0, 8'd50, 8'd60);
        send_line(1, 0, 1'b0, 1'b0);
        set_px(0, 8'd5, 8'd7); set_px(1, 8'd6, 8'd9);
        send_line(2, 0, 1'b0, 1'b0);
        set_px(0, 8'd10, 8'd100); set_px(1, 8'd20, 8'd200);
        set_px(2, 8'd30, 8'd110); set_px(3, 8'd40, 8'd210);
        repeat (4) drive(1'b0, 1'b1, 8'($urandom), 8'($urandom));
        send_line(4, 2, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, dy[i], dc[i]);
        pulse_reset();
        repeat (2) drive(1'b0, 1'b0, 8'd0, 8'd0);
        set_px(0, 8'd1, 8'd2); set_px(1, 8'd3, 8'd4);
        send_line(2, 0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            cur_vs = 1'($urandom);
            drive(1'($urandom), 1'b0, 8'($urandom), 8'($urandom));
        end
        cur_vs = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 8'd0, 8'd0);

        for (int ln = 0; ln < 40; ln++) begin
            for (int i = 0; i < 16; i++) set_px(i, 8'($urandom), 8'($urandom));
            cur_vs = ($urandom_range(0, 7) == 0);
            send_line($urandom_range(1, 12), 3, 1'b1, 1'($urandom));
        end
        cur_vs = 1'b0;
        repeat (6) drive(1'b0, 1'b0, 8'd0, 8'd0);

        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: got %0d pending, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
